// File: rtl/fetch_unit.sv
// Instruction-fetch front end: 8-phase machine-cycle sequencer, 12-bit program counter,
// ROM nibble capture and one/two-byte instruction assembly for the decoder.
module fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  rom_nibble,
  input  logic        pc_load,
  input  logic [11:0] pc_load_addr,
  output logic [11:0] rom_addr,
  output logic [2:0]  cycle,
  output logic        sync,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  output logic [7:0]  op2,
  output logic        two_byte,
  output logic        instr_valid
);

  typedef enum logic {
    FETCH1 = 1'b0,
    FETCH2 = 1'b1
  } state_t;

  localparam logic [2:0] CYC_M1 = 3'd3;
  localparam logic [2:0] CYC_M2 = 3'd4;
  localparam logic [2:0] CYC_X3 = 3'd7;

  // JCN, FIM (even OPA), JUN, JMS and ISZ carry a second byte; FIN is one-byte.
  function automatic logic is_two_byte(input logic [3:0] code_hi, input logic [3:0] code_lo);
    logic result;
    case (code_hi)
      4'h1, 4'h4, 4'h5, 4'h7: result = 1'b1;
      4'h2:                   result = ~code_lo[0];
      default:                result = 1'b0;
    endcase
    return result;
  endfunction

  state_t      state, state_next;
  logic [2:0]  cycle_q, cycle_next;
  logic [11:0] pc_q, pc_next;
  logic [3:0]  opr_q, opr_next;
  logic [3:0]  opa_q, opa_next;
  logic [7:0]  op2_q, op2_next;
  logic        two_byte_q, two_byte_next;
  logic        valid_q, valid_next;
  logic        decode_two;

  // opr already holds this byte's high nibble when the low nibble arrives at M2.
  assign decode_two = is_two_byte(opr_q, rom_nibble);

  always_comb begin
    state_next    = state;
    cycle_next    = cycle_q + 3'd1;
    pc_next       = pc_q;
    opr_next      = opr_q;
    opa_next      = opa_q;
    op2_next      = op2_q;
    two_byte_next = two_byte_q;
    valid_next    = 1'b0;

    case (state)
      FETCH1: begin
        if (cycle_q == CYC_M1) begin
          opr_next = rom_nibble;
        end
        if (cycle_q == CYC_M2) begin
          opa_next      = rom_nibble;
          two_byte_next = decode_two;
          valid_next    = ~decode_two;
        end
        if (cycle_q == CYC_X3 && two_byte_q) begin
          state_next = FETCH2;
        end
      end
      FETCH2: begin
        if (cycle_q == CYC_M1) begin
          op2_next[7:4] = rom_nibble;
        end
        if (cycle_q == CYC_M2) begin
          op2_next[3:0] = rom_nibble;
          valid_next    = 1'b1;
        end
        if (cycle_q == CYC_X3) begin
          state_next = FETCH1;
        end
      end
      default: state_next = FETCH1;
    endcase

    // A jump between the two bytes of an instruction would split it, so it is refused.
    if (cycle_q == CYC_X3) begin
      if (pc_load && (state == FETCH2 || !two_byte_q)) begin
        pc_next = pc_load_addr;
      end else begin
        pc_next = pc_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH1;
      cycle_q    <= 3'd0;
      pc_q       <= RESET_PC;
      opr_q      <= 4'h0;
      opa_q      <= 4'h0;
      op2_q      <= 8'h00;
      two_byte_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (en) begin
      state      <= state_next;
      cycle_q    <= cycle_next;
      pc_q       <= pc_next;
      opr_q      <= opr_next;
      opa_q      <= opa_next;
      op2_q      <= op2_next;
      two_byte_q <= two_byte_next;
      valid_q    <= valid_next;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign rom_addr    = pc_q;
  assign cycle       = cycle_q;
  assign sync        = (cycle_q == CYC_X3);
  assign opr         = opr_q;
  assign opa         = opa_q;
  assign op2         = op2_q;
  assign two_byte    = two_byte_q;
  assign instr_valid = valid_q;

endmodule
